// File: rtl/interlaken_pkg.sv
// Shared definitions for the Interlaken segmented loopback block.
// Holds the per-segment field widths, the default data/channel widths,
// the loopback state encoding and a helper that sizes one stored segment.
package interlaken_pkg;

  localparam int MTYW   = 4;    // empty-byte count per segment
  localparam int FLAGW  = 4;    // ena, sop, eop, err per segment
  localparam int DEF_DW = 128;  // default data bits per segment
  localparam int DEF_CW = 11;   // default channel bits per segment

  // Loopback admission state: PASS forwards words, DROP discards the rest
  // of a packet that lost a word to overflow.
  typedef enum logic {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } lb_state_t;

  // Bits of one segment as stored in the FIFO: data, channel, mty, flags.
  function automatic int seg_width(input int dw, input int cw);
    return dw + cw + MTYW + FLAGW;
  endfunction

endpackage

// File: rtl/interlaken_sync_fifo.sv
// Single-clock FIFO used as the loopback word buffer.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wr_en          push request; ignored while full
//   i_wr_data        word to push
//   i_rd_en          pop request; ignored while empty
//   o_rd_data        head word (combinational read of the head slot)
//   full, empty      occupancy flags taken from the registered count, so a
//                    push while full is refused even if a pop happens too
module interlaken_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_wr   = i_wr_en & ~full;
  assign w_do_rd   = i_rd_en & ~empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage carries no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/interlaken_seg_loopback.sv
// Interlaken segmented RX-to-TX loopback with overflow packet dropping.
// RX words (any enabled segment) are buffered in a FIFO and replayed on the
// TX side. A word that meets a full FIFO is dropped together with the rest
// of its packet; statistics count forwarded EOPs and dropped words.
// Ports:
//   interlaken_clock / interlaken_reset   clock, async active-low reset
//   rx_*        incoming segmented word (data, chan, ena, sop, eop, err, mty)
//   tx_rdyout   core accepts a TX word this cycle
//   tx_*        registered outgoing word, tx_bctlin = inverse of tx_enain
//   stat_clr    synchronous clear of pkt_cnt, drop_cnt, ovf
//   pkt_cnt, drop_cnt, ovf   statistics
//   o_dbg_state current admission state (0 PASS, 1 DROP)
//
// TX handshake: tx_rdyout is the sink's ready. On every edge with
// tx_rdyout=1 the tx_* registers take either the FIFO head (which is then
// popped) or an idle word; with tx_rdyout=0 they hold. There is no separate
// valid: a word with tx_enain all zero is idle.
module interlaken_seg_loopback
  import interlaken_pkg::*;
#(
  parameter int NSEG  = 4,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int DEPTH = 16
) (
  input  logic                 interlaken_clock,
  input  logic                 interlaken_reset,
  input  logic [NSEG*DW-1:0]   rx_datain,
  input  logic [NSEG*CW-1:0]   rx_chanin,
  input  logic [NSEG-1:0]      rx_enain,
  input  logic [NSEG-1:0]      rx_sopin,
  input  logic [NSEG-1:0]      rx_eopin,
  input  logic [NSEG-1:0]      rx_errin,
  input  logic [NSEG*MTYW-1:0] rx_mtyin,
  input  logic                 tx_rdyout,
  output logic [NSEG*DW-1:0]   tx_datain,
  output logic [NSEG*CW-1:0]   tx_chanin,
  output logic [NSEG-1:0]      tx_enain,
  output logic [NSEG-1:0]      tx_sopin,
  output logic [NSEG-1:0]      tx_eopin,
  output logic [NSEG-1:0]      tx_errin,
  output logic [NSEG*MTYW-1:0] tx_mtyin,
  output logic [NSEG-1:0]      tx_bctlin,
  input  logic                 stat_clr,
  output logic [31:0]          pkt_cnt,
  output logic [31:0]          drop_cnt,
  output logic                 ovf,
  output logic                 o_dbg_state
);

  localparam int SEGW = seg_width(DW, CW);
  localparam int WW   = NSEG * SEGW;
  localparam int ECW  = $clog2(NSEG + 1);

  lb_state_t r_state;
  lb_state_t w_state_nxt;

  logic                 w_valid;
  logic                 w_last_eop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_wr_en;
  logic                 w_drop;
  logic                 w_ovf_evt;
  logic [ECW-1:0]       w_eop_cnt;
  logic [32:0]          w_pkt_sum;
  logic [WW-1:0]        w_wr_word;
  logic [WW-1:0]        w_rd_word;

  logic [NSEG*DW-1:0]   w_head_data;
  logic [NSEG*CW-1:0]   w_head_chan;
  logic [NSEG*MTYW-1:0] w_head_mty;
  logic [NSEG-1:0]      w_head_ena;
  logic [NSEG-1:0]      w_head_sop;
  logic [NSEG-1:0]      w_head_eop;
  logic [NSEG-1:0]      w_head_err;

  logic [NSEG*DW-1:0]   r_tx_data;
  logic [NSEG*CW-1:0]   r_tx_chan;
  logic [NSEG-1:0]      r_tx_ena;
  logic [NSEG-1:0]      r_tx_sop;
  logic [NSEG-1:0]      r_tx_eop;
  logic [NSEG-1:0]      r_tx_err;
  logic [NSEG*MTYW-1:0] r_tx_mty;
  logic [NSEG-1:0]      r_tx_bctl;
  logic [31:0]          r_pkt_cnt;
  logic [31:0]          r_drop_cnt;
  logic                 r_ovf;

  assign w_valid = |rx_enain;

  // Per-segment word analysis: the eop of the highest enabled segment
  // (ascending scan, last enabled segment wins) and the enabled-eop count.
  always_comb begin
    w_last_eop = 1'b0;
    w_eop_cnt  = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (rx_enain[i]) w_last_eop = rx_eopin[i];
      w_eop_cnt = w_eop_cnt + ECW'(rx_eopin[i] & rx_enain[i]);
    end
  end

  // Segment i occupies [i*SEGW +: SEGW] as {data, chan, mty, ena, sop, eop, err}.
  always_comb begin
    w_wr_word = '0;
    for (int i = 0; i < NSEG; i++) begin
      w_wr_word[i*SEGW +: SEGW] = {rx_datain[i*DW +: DW], rx_chanin[i*CW +: CW],
                                   rx_mtyin[i*MTYW +: MTYW], rx_enain[i],
                                   rx_sopin[i], rx_eopin[i], rx_errin[i]};
    end
  end

  always_comb begin
    w_head_data = '0;
    w_head_chan = '0;
    w_head_mty  = '0;
    w_head_ena  = '0;
    w_head_sop  = '0;
    w_head_eop  = '0;
    w_head_err  = '0;
    for (int i = 0; i < NSEG; i++) begin
      {w_head_data[i*DW +: DW], w_head_chan[i*CW +: CW], w_head_mty[i*MTYW +: MTYW],
       w_head_ena[i], w_head_sop[i], w_head_eop[i], w_head_err[i]} = w_rd_word[i*SEGW +: SEGW];
    end
  end

  // Admission FSM. The word that causes overflow only enters DROP; exit is
  // decided on later words seen while already in DROP.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_ovf_evt   = 1'b0;
    case (r_state)
      ST_PASS: begin
        if (w_valid) begin
          if (w_full) begin
            w_drop      = 1'b1;
            w_ovf_evt   = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_wr_en = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (w_valid) begin
          w_drop = 1'b1;
          if (w_last_eop) w_state_nxt = ST_PASS;
        end
      end
      default: w_state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge interlaken_clock or negedge interlaken_reset) begin
    if (!interlaken_reset) r_state <= ST_PASS;
    else                   r_state <= w_state_nxt;
  end

  interlaken_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (interlaken_clock),
    .i_rst_n   (interlaken_reset),
    .i_wr_en   (w_wr_en),
    .i_wr_data (w_wr_word),
    .i_rd_en   (tx_rdyout),
    .o_rd_data (w_rd_word),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge interlaken_clock or negedge interlaken_reset) begin
    if (!interlaken_reset) begin
      r_tx_data <= '0;
      r_tx_chan <= '0;
      r_tx_ena  <= '0;
      r_tx_sop  <= '0;
      r_tx_eop  <= '0;
      r_tx_err  <= '0;
      r_tx_mty  <= '0;
      r_tx_bctl <= '1;
    end else if (tx_rdyout) begin
      if (!w_empty) begin
        r_tx_data <= w_head_data;
        r_tx_chan <= w_head_chan;
        r_tx_ena  <= w_head_ena;
        r_tx_sop  <= w_head_sop;
        r_tx_eop  <= w_head_eop;
        r_tx_err  <= w_head_err;
        r_tx_mty  <= w_head_mty;
        r_tx_bctl <= ~w_head_ena;
      end else begin
        r_tx_data <= '0;
        r_tx_chan <= '0;
        r_tx_ena  <= '0;
        r_tx_sop  <= '0;
        r_tx_eop  <= '0;
        r_tx_err  <= '0;
        r_tx_mty  <= '0;
        r_tx_bctl <= '1;
      end
    end
  end

  // Wide sum so the carry out signals saturation.
  assign w_pkt_sum = {1'b0, r_pkt_cnt} + 33'(w_eop_cnt);

  // stat_clr wins over any increment in the same cycle.
  always_ff @(posedge interlaken_clock or negedge interlaken_reset) begin
    if (!interlaken_reset) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (stat_clr) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr_en) r_pkt_cnt <= w_pkt_sum[32] ? 32'hFFFF_FFFF : w_pkt_sum[31:0];
      if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_ovf_evt) r_ovf <= 1'b1;
    end
  end

  assign tx_datain   = r_tx_data;
  assign tx_chanin   = r_tx_chan;
  assign tx_enain    = r_tx_ena;
  assign tx_sopin    = r_tx_sop;
  assign tx_eopin    = r_tx_eop;
  assign tx_errin    = r_tx_err;
  assign tx_mtyin    = r_tx_mty;
  assign tx_bctlin   = r_tx_bctl;
  assign pkt_cnt     = r_pkt_cnt;
  assign drop_cnt    = r_drop_cnt;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_interlaken_seg_loopback.sv
// Testbench for interlaken_seg_loopback: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
module tb_interlaken_seg_loopback;

  localparam int NSEG  = 4;
  localparam int DW    = 128;
  localparam int CW    = 11;
  localparam int MTYW  = 4;
  localparam int DEPTH = 16;
  localparam int TW    = NSEG * (DW + CW + MTYW + 4);
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NSEG*DW-1:0]   rx_datain = '0;
  logic [NSEG*CW-1:0]   rx_chanin = '0;
  logic [NSEG-1:0]      rx_enain  = '0;
  logic [NSEG-1:0]      rx_sopin  = '0;
  logic [NSEG-1:0]      rx_eopin  = '0;
  logic [NSEG-1:0]      rx_errin  = '0;
  logic [NSEG*MTYW-1:0] rx_mtyin  = '0;
  logic                 tx_rdyout = 1'b0;
  logic                 stat_clr  = 1'b0;
  logic [NSEG*DW-1:0]   tx_datain;
  logic [NSEG*CW-1:0]   tx_chanin;
  logic [NSEG-1:0]      tx_enain;
  logic [NSEG-1:0]      tx_sopin;
  logic [NSEG-1:0]      tx_eopin;
  logic [NSEG-1:0]      tx_errin;
  logic [NSEG*MTYW-1:0] tx_mtyin;
  logic [NSEG-1:0]      tx_bctlin;
  logic [31:0]          pkt_cnt;
  logic [31:0]          drop_cnt;
  logic                 ovf;
  logic                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [TW-1:0] exp_q[$];   // words the model accepted and not yet emitted
  logic [TW-1:0] tx_log[$];  // non-idle words emitted, for directed counts

  // reference model state
  int     m_occ    = 0;
  bit     m_drop   = 1'b0;
  bit     m_pop    = 1'b0;
  bit     m_accept = 1'b0;
  longint m_pkt    = 0;
  longint m_dropc  = 0;
  bit     m_ovf    = 1'b0;

  interlaken_seg_loopback #(
    .NSEG (NSEG), .DW (DW), .CW (CW), .DEPTH (DEPTH)
  ) dut (
    .interlaken_clock (clk),
    .interlaken_reset (rst_n),
    .rx_datain        (rx_datain),
    .rx_chanin        (rx_chanin),
    .rx_enain         (rx_enain),
    .rx_sopin         (rx_sopin),
    .rx_eopin         (rx_eopin),
    .rx_errin         (rx_errin),
    .rx_mtyin         (rx_mtyin),
    .tx_rdyout        (tx_rdyout),
    .tx_datain        (tx_datain),
    .tx_chanin        (tx_chanin),
    .tx_enain         (tx_enain),
    .tx_sopin         (tx_sopin),
    .tx_eopin         (tx_eopin),
    .tx_errin         (tx_errin),
    .tx_mtyin         (tx_mtyin),
    .tx_bctlin        (tx_bctlin),
    .stat_clr         (stat_clr),
    .pkt_cnt          (pkt_cnt),
    .drop_cnt         (drop_cnt),
    .ovf              (ovf),
    .o_dbg_state      (dbg_state)
  );

  // Bench view of a word: {data, chan, mty, ena, sop, eop, err}.
  function automatic logic [TW-1:0] pack_tx(
    input logic [NSEG*DW-1:0] data, input logic [NSEG*CW-1:0] chan,
    input logic [NSEG*MTYW-1:0] mty, input logic [NSEG-1:0] ena,
    input logic [NSEG-1:0] sop, input logic [NSEG-1:0] eop, input logic [NSEG-1:0] err);
    return {data, chan, mty, ena, sop, eop, err};
  endfunction

  function automatic logic [TW-1:0] pack_rx();
    return pack_tx(rx_datain, rx_chanin, rx_mtyin, rx_enain, rx_sopin, rx_eopin, rx_errin);
  endfunction

  function automatic logic [TW-1:0] pack_dut();
    return pack_tx(tx_datain, tx_chanin, tx_mtyin, tx_enain, tx_sopin, tx_eopin, tx_errin);
  endfunction

  function automatic bit last_seg_eop(input logic [NSEG-1:0] ena, input logic [NSEG-1:0] eop);
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (ena[i]) return eop[i];
    end
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bounded queue with DEPTH slots; a word is admitted only when the queue
  // held fewer than DEPTH words before this edge and no packet is being
  // discarded.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ   = 0;
      m_drop  = 1'b0;
      m_pop   = 1'b0;
      m_pkt   = 0;
      m_dropc = 0;
      m_ovf   = 1'b0;
    end else begin
      m_accept = 1'b0;
      if (rx_enain != '0) begin
        if (!m_drop && m_occ < DEPTH) begin
          m_accept = 1'b1;
        end else begin
          if (m_dropc < CMAX) m_dropc = m_dropc + 1;
          if (!m_drop) begin
            m_drop = 1'b1;
            m_ovf  = 1'b1;
          end else if (last_seg_eop(rx_enain, rx_eopin)) begin
            m_drop = 1'b0;
          end
        end
      end
      m_pop = tx_rdyout && (m_occ > 0);
      if (m_accept) begin
        exp_q.push_back(pack_rx());
        m_pkt = m_pkt + $countones(rx_eopin & rx_enain);
        if (m_pkt > CMAX) m_pkt = CMAX;
      end
      m_occ = m_occ + (m_accept ? 1 : 0) - (m_pop ? 1 : 0);
      if (stat_clr) begin
        m_pkt   = 0;
        m_dropc = 0;
        m_ovf   = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic          rdy_s;
    logic [TW-1:0] exp_tx;
    logic [TW-1:0] act;
    logic [NSEG-1:0] exp_bctl;
    exp_tx = '0;
    forever begin
      @(posedge clk);
      rdy_s = tx_rdyout;
      #1;
      if (!rst_n) begin
        exp_tx = '0;
      end else if (rdy_s) begin
        if (m_pop && exp_q.size() > 0) exp_tx = exp_q.pop_front();
        else                           exp_tx = '0;
      end
      act = pack_dut();
      if (rst_n && rdy_s && tx_enain != '0) tx_log.push_back(act);
      exp_bctl = ~exp_tx[3*NSEG +: NSEG];
      chk("tx_word",  act, exp_tx);
      chk("tx_bctl",  TW'(tx_bctlin), TW'(exp_bctl));
      chk("pkt_cnt",  TW'(pkt_cnt),   TW'(m_pkt[31:0]));
      chk("drop_cnt", TW'(drop_cnt),  TW'(m_dropc[31:0]));
      chk("ovf",      TW'(ovf),       TW'(m_ovf));
      chk("state",    TW'(dbg_state), TW'(m_drop));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [NSEG-1:0] ena, input logic [NSEG-1:0] sop,
                            input logic [NSEG-1:0] eop, input logic clr);
    @(negedge clk);
    for (int k = 0; k < NSEG*DW/32; k++) rx_datain[k*32 +: 32] = $urandom;
    for (int s = 0; s < NSEG; s++) rx_chanin[s*CW +: CW] = CW'($urandom);
    rx_mtyin = (NSEG*MTYW)'($urandom);
    rx_errin = NSEG'($urandom);
    rx_enain = ena;
    rx_sopin = sop;
    rx_eopin = eop;
    stat_clr = clr;
  endtask

  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx_enain = '0;
      rx_sopin = '0;
      rx_eopin = '0;
      stat_clr = 1'b0;
    end
  endtask

  task automatic drive_rand(input int rdy_pct);
    logic [NSEG-1:0] ena;
    ena = ($urandom_range(0, 3) == 0) ? '0 : NSEG'($urandom_range(1, 15));
    drive_word(ena, NSEG'($urandom), NSEG'($urandom), ($urandom_range(0, 99) == 0));
    tx_rdyout = ($urandom_range(0, 99) < rdy_pct);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TW-1:0] w_exp;
    logic [TW-1:0] w_sop;

    repeat (3) @(negedge clk);
    chk("reset_bctl", TW'(tx_bctlin), TW'(4'b1111));
    chk("reset_pkt",  TW'(pkt_cnt),   TW'(0));
    rst_n = 1'b1;

    // single packet, latency 2
    tx_rdyout = 1'b1;
    drive_idle(2);
    drive_word(4'b1111, 4'b0001, 4'b1000, 1'b0);
    w_exp = pack_rx();
    drive_idle(1);
    chk("lat_cycle1_idle", TW'(tx_enain), TW'(0));
    drive_idle(1);
    chk("lat_cycle2_word", pack_dut(), w_exp);
    chk("lat_cycle2_bctl", TW'(tx_bctlin), TW'(4'b0000));
    chk("lat_pkt_cnt",     TW'(pkt_cnt),   TW'(1));
    drive_idle(1);

    // backpressure fill, then overflow
    tx_rdyout = 1'b0;
    tx_log.delete();
    for (int k = 0; k < DEPTH; k++) drive_word(4'b1111, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
    drive_idle(1);
    chk("fill_hold_idle", TW'(tx_bctlin), TW'(4'b1111));
    drive_word(4'b1111, 4'b0000, 4'b0000, 1'b0);
    drive_idle(1);
    chk("ovf_drop_cnt", TW'(drop_cnt),  TW'(1));
    chk("ovf_flag",     TW'(ovf),       TW'(1));
    chk("ovf_state",    TW'(dbg_state), TW'(1));

    // leave DROP on eop in segment 3, then a new packet
    drive_word(4'b1111, 4'b0000, 4'b1000, 1'b0);
    drive_idle(1);
    chk("exit_drop_cnt", TW'(drop_cnt),  TW'(2));
    chk("exit_state",    TW'(dbg_state), TW'(0));
    tx_rdyout = 1'b1;
    drive_idle(1);
    tx_rdyout = 1'b0;
    drive_word(4'b1111, 4'b0001, 4'b0000, 1'b0);
    w_sop = pack_rx();
    drive_idle(1);
    chk("sop_not_dropped", TW'(drop_cnt), TW'(2));
    tx_rdyout = 1'b1;
    drive_idle(DEPTH + 4);
    chk("drain_count", TW'(tx_log.size()), TW'(17));
    if (tx_log.size() >= 17) chk("sop_is_17th", tx_log[16], w_sop);

    // push while full with a same-cycle pop: push refused
    tx_rdyout = 1'b0;
    for (int k = 0; k < DEPTH; k++) drive_word(4'b1111, 4'b0000, 4'b0000, 1'b0);
    tx_log.delete();
    drive_word(4'b1111, 4'b0000, 4'b0000, 1'b0);
    tx_rdyout = 1'b1;
    drive_idle(1);
    tx_rdyout = 1'b0;
    chk("full_pop_drop", TW'(drop_cnt),  TW'(3));
    chk("full_pop_state", TW'(dbg_state), TW'(1));
    // highest enabled segment (1) has no eop: stay in DROP
    drive_word(4'b0011, 4'b0000, 4'b0001, 1'b0);
    drive_idle(1);
    chk("drop_stay_state", TW'(dbg_state), TW'(1));
    drive_word(4'b0011, 4'b0000, 4'b0010, 1'b0);
    drive_idle(1);
    chk("drop_exit2_state", TW'(dbg_state), TW'(0));
    chk("drop_exit2_cnt",   TW'(drop_cnt),  TW'(5));
    tx_rdyout = 1'b1;
    drive_idle(DEPTH + 4);
    chk("full_pop_total", TW'(tx_log.size()), TW'(16));

    // reset mid-packet with 5 words buffered
    tx_rdyout = 1'b0;
    for (int k = 0; k < 6; k++) drive_word(4'b1111, (k == 0) ? 4'b0001 : 4'b0000, 4'b0000, 1'b0);
    tx_rdyout = 1'b1;
    drive_idle(1);
    tx_rdyout = 1'b0;
    chk("pre_reset_busy", TW'(tx_enain), TW'(4'b1111));
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_now_bctl", TW'(tx_bctlin), TW'(4'b1111));
    chk("reset_now_word", pack_dut(), TW'(0));
    chk("reset_now_drop", TW'(drop_cnt), TW'(0));
    repeat (2) @(negedge clk);
    tx_log.delete();
    rst_n = 1'b1;
    tx_rdyout = 1'b1;
    drive_idle(10);
    chk("no_stale_words", TW'(tx_log.size()), TW'(0));

    // stat_clr beats a same-cycle eop write
    drive_word(4'b0001, 4'b0001, 4'b0001, 1'b1);
    drive_idle(1);
    chk("clr_priority", TW'(pkt_cnt), TW'(0));
    drive_word(4'b1111, 4'b0000, 4'b1010, 1'b0);
    drive_idle(1);
    chk("pkt_after_clr", TW'(pkt_cnt), TW'(2));

    // randomized traffic, alternating light and heavy backpressure
    for (int ph = 0; ph < 16; ph++) begin
      for (int c = 0; c < 100; c++) drive_rand((ph % 2 == 1) ? 25 : 90);
    end

    tx_rdyout = 1'b1;
    drive_idle(DEPTH + 5);
    chk("final_drained", TW'(exp_q.size()), TW'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
